// File: rtl/fadd_pkg.sv
// Shared types and helpers for the fadd pipeline scheduler.
package fadd_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } sched_state_t;

  localparam int LAT_DEFAULT = 3;

  // Requester id width; kept at least 1 bit so vectors stay legal.
  function automatic int id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/fadd_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or above ptr, wrapping.
module rr_arbiter
  import fadd_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [NREQ-1:0]   pick_rot;
  logic [2*NREQ-1:0] pick_dbl;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_dbl  = {req, req} >> ptr;
    req_rot  = req_dbl[NREQ-1:0];
    pick_rot = req_rot & (-req_rot);
    pick_dbl = {pick_rot, pick_rot} << ptr;
    gnt      = pick_dbl[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/fadd_sched.sv
// Shares one fadd pipeline among NREQ requesters with round-robin issue,
// id tagging of in-flight operations, result return and quiesce/drain.
module fadd_sched
  import fadd_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int LAT  = LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_op1,
  input  logic [NREQ*N-1:0] req_op2,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_data,
  output logic              fadd_en,
  output logic [N-1:0]      fadd_op1,
  output logic [N-1:0]      fadd_op2,
  input  logic              fadd_res_val,
  input  logic [N-1:0]      fadd_res,
  input  logic              quiesce,
  output logic              idle,
  output logic              err,
  output sched_state_t      fsm_state
);

  localparam int ID_W  = id_w(NREQ);
  localparam int CNT_W = $clog2(LAT + 2);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  sched_state_t state, state_next;
  logic [ID_W-1:0]            ptr, ptr_next, win_id, issue_id;
  logic [NREQ-1:0]            gnt;
  logic                       xfer;
  logic [N-1:0]               win_op1, win_op2;
  logic [LAT-1:0]             tag_v;
  logic [LAT-1:0][ID_W-1:0]   tag_id;
  logic [CNT_W-1:0]           cnt;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  // Handshake: requester i transfers in any cycle where req_valid[i] and
  // req_ready[i] are both high; ready never waits on anything but state,
  // quiesce and the arbiter, so a held valid is granted with no bubble.
  always_comb begin
    req_ready = (state == RUN && !quiesce) ? gnt : '0;
    xfer      = |(req_valid & req_ready);
    win_id    = '0;
    win_op1   = '0;
    win_op2   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        win_id  = ID_W'(i);
        win_op1 = req_op1[i*N +: N];
        win_op2 = req_op2[i*N +: N];
      end
    end
    ptr_next = (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + ID_W'(1);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (quiesce) state_next = DRAIN;
      DRAIN:   if (!quiesce) state_next = RUN;
               else if (cnt == '0) state_next = IDLE;
      IDLE:    if (!quiesce) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign idle      = (state == IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      ptr      <= '0;
      issue_id <= '0;
      fadd_en  <= 1'b0;
      fadd_op1 <= '0;
      fadd_op2 <= '0;
    end else begin
      state   <= state_next;
      fadd_en <= xfer;
      if (xfer) begin
        ptr      <= ptr_next;
        issue_id <= win_id;
        fadd_op1 <= win_op1;
        fadd_op2 <= win_op2;
      end
    end
  end

  // Tag pipe mirrors the adder latency; its last stage lines up with fadd_res_val.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= fadd_en;
      tag_id[0] <= issue_id;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      unique case ({xfer, tag_v[LAT-1]})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= (fadd_res_val && tag_v[LAT-1]) ? (ONE << tag_id[LAT-1]) : '0;
      if (fadd_res_val) rsp_data <= fadd_res;
      if (fadd_res_val != tag_v[LAT-1]) err <= 1'b1;
    end
  end

endmodule

// File: doc/fadd_sched.md
# fadd_sched

Round-robin scheduler that shares one `fadd` pipeline among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The scheduler issues at most one operation per cycle into the adder and tracks the requester ID of every in-flight operation. It returns each result to its originating requester and provides a quiesce/drain control for reset and reconfiguration sequencing.

## Interface
- `N`, 32: float width, passed through to the adder ports.
- `NREQ`, 4: number of requesters, 2..8.
- `LAT`, 3: adder latency, cycles from `fadd_en` high to `fadd_res_val` high.
- `clk`  in  1: clock. One clock domain.
- `rst_n`  in  1: reset. Asynchronous, active-low.
- `req_valid`  in  NREQ: per-requester operation valid.
- `req_ready`  out  NREQ: per-requester accept. One-hot or zero.
- `req_op1`, `req_op2`  in  NREQ×N: packed operand arrays; slice i belongs to requester i.
- `rsp_valid`  out  NREQ: per-requester result strobe. One-hot or zero. No backpressure.
- `rsp_data`  out  N: result, qualified by `rsp_valid`.
- `fadd_en`  out  1: adder issue strobe.
- `fadd_op1`, `fadd_op2`  out  N: adder operands.
- `fadd_res_val`  in  1: adder result valid.
- `fadd_res`  in  N: adder result.
- `quiesce`  in  1: stop accepting new work and drain in-flight operations.
- `idle`  out  1: scheduler is in IDLE state. Nothing is in flight.
- `err`  out  1: sticky. Set on an adder/tag valid mismatch.

## Operation
- Arbitration:
  - `req_ready[i]` is combinational. It is high only in state RUN, and only for the winning requester.
  - The winner is the first requester with `req_valid` set, searching from `ptr` upward and wrapping modulo NREQ.
  - A transfer occurs when `req_valid[i] & req_ready[i]`. The same cycle, `ptr` moves to i+1 (wrapping from NREQ-1 to 0).
  - `ptr` holds when there is no transfer.
- Issue:
  - On a transfer, `fadd_en`, `fadd_op1` and `fadd_op2` are registered from the winner's slice.
  - Otherwise `fadd_en` is 0 and the operand registers hold their previous values.
- Tag pipe: a LAT-stage shift register of {valid, id}.
  - Stage 0 loads {`fadd_en`, issued id}. It advances every cycle.
  - The final stage aligns with `fadd_res_val`.
- Return:
  - When `fadd_res_val` is high, the scheduler registers `rsp_valid` as one-hot of the final-stage id and registers `rsp_data` from `fadd_res`.
  - Otherwise `rsp_valid` is 0.
- Check:
  - If `fadd_res_val` differs from the final-stage valid bit, `err` sets and stays set until reset.
  - When `fadd_res_val` is high without a tag, no response is produced.
- In-flight counter:
  - Counts the operations held in the issue register plus the tag pipe.
  - Increments on a transfer and decrements on a final-stage valid. A simultaneous increment and decrement leaves it unchanged.
  - Width is $clog2(LAT+2).
- State machine, encoded as a 2-bit enum:
  - RUN: normal operation. `quiesce`=1 → DRAIN. From the same cycle, `req_ready` is forced to 0.
  - DRAIN: `req_ready` is 0. If `quiesce`=0, go to RUN. Otherwise, when the in-flight count is 0, go to IDLE.
  - IDLE: `idle`=1 and `req_ready` is 0. `quiesce`=0 → RUN.
- Reset values: state RUN, `ptr` 0, tag pipe all invalid, in-flight count 0. Outputs: `fadd_en` 0, `fadd_op1`/`fadd_op2` 0, `rsp_valid` 0, `rsp_data` 0, `err` 0, `idle` 0.
- Reset asserted mid-operation discards all in-flight tags.
  - The adder must be reset in the same window; the system integrator is responsible for this.
  - Any adder result arriving after reset without a tag sets `err`.

## Timing
- Transfer in cycle c → `fadd_en` in c+1 → `fadd_res_val` in c+1+LAT → `rsp_valid` in c+2+LAT. With LAT=3, this is c+5.
- Sustained throughput is one operation per cycle. Results return in issue order.
- An arbitration decision takes effect in the same cycle as `req_valid`. There is no bubble between back-to-back grants.
- In DRAIN, `idle` rises no earlier than the cycle after the last in-flight response's `fadd_res_val`.

## Structure
- `fadd_pkg` holds:
  - the `sched_state_t` enum (RUN, DRAIN, IDLE);
  - the default `LAT` localparam;
  - the `ID_W` = $clog2(NREQ) helper.
- Sub-module `rr_arbiter`, parameterised by NREQ:
  - inputs: `req` vector, `ptr`;
  - output: one-hot `gnt`.
- Tag pipe, counter and FSM stay in `fadd_sched`. Target size is about 200 lines.

## Test plan
- Single request: requester 2 sends op1=0x3F800000, op2=0x40000000 in cycle 10 → `fadd_en` in cycle 11 → `rsp_valid`=0b0100 with `rsp_data`=0x40400000 in cycle 15.
- All four requesters valid continuously for 8 cycles → grants in order 0,1,2,3,0,1,2,3 → `rsp_valid` in the same order, one per cycle, each data matching its own operands.
- Requesters 1 and 3 valid with `ptr`=2 → requester 3 wins, `ptr` becomes 0, then requester 1 wins.
- Assert `quiesce` with 3 operations in flight → `req_ready` is 0 in the same cycle, all 3 responses are delivered, `idle`=1 the cycle after the count reaches 0. Deassert `quiesce` → RUN, and grants resume the next cycle.
- Force `fadd_res_val`=1 with an empty tag pipe → `err`=1, no `rsp_valid`, `err` persists until `rst_n` pulses low.
- Drop `rst_n` asynchronously with 2 operations in flight → all outputs return to reset values immediately, and no stale `rsp_valid` appears after release.
